// File: rtl/sc_bitstream_decoder_if.sv
// Bundle of the control, bitstream-input and result-output signals of sc_bitstream_decoder.
// Pure wiring; no latency of its own.
// bit_valid/bit_ready and out_valid/out_ready are independent valid-ready pairs.
interface sc_bitstream_decoder_if #(
  parameter int CWID = 8,
  parameter int WL2  = $clog2(CWID + 1)
) ();
  logic            clr;
  logic            start;
  logic [WL2-1:0]  win_log2;
  logic            bit_valid;
  logic            bit_in;
  logic            bit_ready;
  logic            out_valid;
  logic            out_ready;
  logic [CWID:0]   out_cnt;
  logic [CWID+1:0] out_bip;
  logic            busy;

  modport master (
    output clr, start, win_log2, bit_valid, bit_in, out_ready,
    input  bit_ready, out_valid, out_cnt, out_bip, busy
  );

  modport slave (
    input  clr, start, win_log2, bit_valid, bit_in, out_ready,
    output bit_ready, out_valid, out_cnt, out_bip, busy
  );
endinterface

// File: rtl/sc_bitstream_decoder.sv
// Stochastic bitstream decoder: counts 1s over 2^win accepted beats, emits unipolar and bipolar results.
// Result registered the cycle after the final beat; load and consume may coincide.
// A finished window waits in HOLD (bit_ready low) while the single result slot is occupied.
module sc_bitstream_decoder #(
  parameter int CWID = 8,
  parameter int WL2  = $clog2(CWID + 1)
) (
  input logic clk,
  input logic rst_n,
  sc_bitstream_decoder_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]      state;
  logic [CWID:0]   acc;
  logic [CWID:0]   beats;
  logic [WL2-1:0]  win;
  logic            out_valid_q;
  logic [CWID:0]   cnt_q;
  logic [CWID+1:0] bip_q;

  logic [WL2-1:0]  win_clamped;
  logic [CWID:0]   win_len;
  logic [CWID:0]   sum;
  logic [CWID+1:0] sum_bip;
  logic [CWID+1:0] acc_bip;
  logic            accept;
  logic            final_beat;
  logic            slot_free;

  // Window bookkeeping: clamped exponent, window length, running sum and bipolar forms.
  always_comb begin
    win_clamped = (bus.win_log2 > WL2'(CWID)) ? WL2'(CWID) : bus.win_log2;
    win_len     = (CWID + 1)'(1) << win;
    sum         = acc + {{CWID{1'b0}}, bus.bit_in};
    // 2*n - 2^win; the extra bit keeps the full -2^win..+2^win range.
    sum_bip     = {sum, 1'b0} - {1'b0, win_len};
    acc_bip     = {acc, 1'b0} - {1'b0, win_len};
    accept      = bus.bit_valid && (state == S_ACC);
    final_beat  = accept && (beats == win_len - (CWID + 1)'(1));
    slot_free   = !out_valid_q || bus.out_ready;
  end

  // Window FSM, accumulator and single-entry result register; clr wins over everything else.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      acc         <= '0;
      beats       <= '0;
      win         <= '0;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
      bip_q       <= '0;
    end else if (bus.clr) begin
      state       <= S_IDLE;
      acc         <= '0;
      beats       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      // Consumption drops the valid unless a load below re-asserts it this cycle.
      if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            win   <= win_clamped;
            acc   <= '0;
            beats <= '0;
            state <= S_ACC;
          end
        end
        S_ACC: begin
          if (final_beat) begin
            if (slot_free) begin
              cnt_q       <= sum;
              bip_q       <= sum_bip;
              out_valid_q <= 1'b1;
              state       <= S_IDLE;
            end else begin
              acc   <= sum;
              state <= S_HOLD;
            end
          end else if (accept) begin
            acc   <= sum;
            beats <= beats + (CWID + 1)'(1);
          end
        end
        S_HOLD: begin
          if (slot_free) begin
            cnt_q       <= acc;
            bip_q       <= acc_bip;
            out_valid_q <= 1'b1;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.bit_ready = (state == S_ACC);
  assign bus.out_valid = out_valid_q;
  assign bus.out_cnt   = cnt_q;
  assign bus.out_bip   = bip_q;
  assign bus.busy      = (state != S_IDLE);

endmodule
